// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// uart_tx_arbiter_pkg: shared constants, state encoding and header helper.
// Rev 1.0
package uart_tx_arbiter_pkg;

  localparam int         ID_W             = 3;
  localparam logic [3:0] HDR_NIBBLE       = 4'hA;
  localparam int         DEF_BUSY_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    HDR_START = 3'd2,
    HDR_WAIT  = 3'd3,
    PAY_START = 3'd4,
    PAY_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  function automatic logic [7:0] make_header(input logic [ID_W-1:0] id);
    return {HDR_NIBBLE, 1'b0, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// sync_2ff: two-flop synchroniser for a single-bit level signal.
// Rev 1.0
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// rr_arbiter: picks the first active request at or after ptr+1, wrapping.
// Rev 1.0
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        valid = 1'b1;
        idx   = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ producers.
// Rev 1.0
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADD_HEADER   = 1,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           data_to_tx,
  output logic                 start_tx,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_valid;
  logic [7:0]        pay_reg;
  logic [7:0]        sel_byte;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              busy_s;
  logic [1:0]        settle;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tx_busy),
    .q     (busy_s)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) sel_byte = data_in[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      gnt_id      <= '0;
      pay_reg     <= '0;
      data_to_tx  <= '0;
      start_tx    <= 1'b0;
      busy        <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      settle      <= '0;
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
      // busy_s is only trustworthy once the synchroniser has refilled after reset
      settle      <= {settle[0], 1'b1};
      case (state)
        IDLE: begin
          if (settle[1] && !busy_s && arb_valid) begin
            gnt_id  <= arb_idx;
            pay_reg <= sel_byte;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          tmo_cnt  <= '0;
          start_tx <= 1'b1;
          if (ADD_HEADER != 0) begin
            data_to_tx <= make_header(gnt_id);
            state      <= HDR_START;
          end else begin
            data_to_tx <= pay_reg;
            state      <= PAY_START;
          end
        end
        HDR_START, PAY_START: begin
          if (busy_s) begin
            start_tx <= 1'b0;
            tmo_cnt  <= '0;
            state    <= (state == HDR_START) ? HDR_WAIT : PAY_WAIT;
          end else if (tmo_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            // rr_ptr is left alone so the same requester retries first
            timeout_err <= 1'b1;
            start_tx    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        HDR_WAIT: begin
          if (!busy_s) begin
            data_to_tx <= pay_reg;
            start_tx   <= 1'b1;
            tmo_cnt    <= '0;
            state      <= PAY_START;
          end
        end
        PAY_WAIT: begin
          if (!busy_s) begin
            ack   <= NUM_REQ'(1) << gnt_id;
            state <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= gnt_id;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed bench with a behavioural uart_tx responder per DUT.
// Rev 1.0
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_a, req_b;
  logic [31:0] din_a, din_b;
  logic [3:0]  ack_a, ack_b;
  logic [7:0]  dtx_a, dtx_b;
  logic        start_a, start_b, busy_a, busy_b, terr_a, terr_b;
  logic        txb_a = 1'b0;
  logic        txb_b = 1'b0;
  logic        en_a  = 1'b1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .ADD_HEADER(1), .BUSY_TIMEOUT(64)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .data_in(din_a), .ack(ack_a),
    .data_to_tx(dtx_a), .start_tx(start_a), .tx_busy(txb_a), .busy(busy_a),
    .timeout_err(terr_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .ADD_HEADER(0), .BUSY_TIMEOUT(64)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .data_in(din_b), .ack(ack_b),
    .data_to_tx(dtx_b), .start_tx(start_b), .tx_busy(txb_b), .busy(busy_b),
    .timeout_err(terr_b)
  );

  // uart_tx stand-ins: accept a byte on start_tx, stay busy for 12 cycles
  int         rem_a = 0;
  int         rem_b = 0;
  logic [7:0] log_a[$];
  logic [7:0] log_b[$];

  always @(posedge clk) begin
    if (txb_a) begin
      if (rem_a == 0) txb_a <= 1'b0;
      else rem_a <= rem_a - 1;
    end else if (start_a && en_a) begin
      txb_a <= 1'b1;
      rem_a <= 11;
      log_a.push_back(dtx_a);
    end
    if (txb_b) begin
      if (rem_b == 0) txb_b <= 1'b0;
      else rem_b <= rem_b - 1;
    end else if (start_b) begin
      txb_b <= 1'b1;
      rem_b <= 11;
      log_b.push_back(dtx_b);
    end
  end

  int         cyc = 0;
  logic       prev_start_a = 1'b0, prev_start_b = 1'b0, prev_terr_a = 1'b0;
  logic [7:0] prev_dtx_a = 8'h00, prev_dtx_b = 8'h00;
  int         start_rise_cyc_a = 0, terr_cyc_a = 0, terr_cnt_a = 0;
  int         ack_cnt_a = 0, ack_cnt_b = 0;
  int         start_rises_b = 0, cur_len_b = 0, last_len_b = 0;
  int         viol_a = 0, viol_b = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    prev_start_a <= start_a;
    prev_start_b <= start_b;
    prev_terr_a  <= terr_a;
    prev_dtx_a   <= dtx_a;
    prev_dtx_b   <= dtx_b;
    if (start_a && !prev_start_a) start_rise_cyc_a <= cyc;
    if (terr_a && !prev_terr_a) begin
      terr_cnt_a <= terr_cnt_a + 1;
      terr_cyc_a <= cyc;
    end
    if (ack_a != 4'b0) ack_cnt_a <= ack_cnt_a + 1;
    if (ack_b != 4'b0) ack_cnt_b <= ack_cnt_b + 1;
    if (start_b && !prev_start_b) start_rises_b <= start_rises_b + 1;
    if (start_b) cur_len_b <= cur_len_b + 1;
    else begin
      if (prev_start_b) last_len_b <= cur_len_b;
      cur_len_b <= 0;
    end
    if (start_a && prev_start_a && dtx_a != prev_dtx_a) viol_a <= viol_a + 1;
    if (start_b && prev_start_b && dtx_b != prev_dtx_b) viol_b <= viol_b + 1;
  end

  task automatic wait_ack_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_a != 4'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_ack_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_b != 4'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_a, start_a, busy_a, terr_a, dtx_a} !== 15'h0) begin
      fails++;
      $display("FAIL reset_a: got %h required 0", {ack_a, start_a, busy_a, terr_a, dtx_a});
    end
    checks++;
    if ({ack_b, start_b, busy_b, terr_b, dtx_b} !== 15'h0) begin
      fails++;
      $display("FAIL reset_b: got %h required 0", {ack_b, start_b, busy_b, terr_b, dtx_b});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || start_a !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b start=%b required 0 0", busy_a, start_a);
    end
  endtask

  task automatic test_single_header();
    bit          ok;
    logic [15:0] got;
    int          base;
    log_a.delete();
    base = ack_cnt_a;
    din_a[23:16] = 8'h5C;
    req_a = 4'b0100;
    wait_ack_a(400, ok);
    req_a = 4'b0000;
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL single_ack_seen: got %b required 1", ok);
    end
    checks++;
    if (ack_a !== 4'b0100) begin
      fails++;
      $display("FAIL single_ack_vec: got %b required 0100", ack_a);
    end
    checks++;
    if (txb_a !== 1'b0) begin
      fails++;
      $display("FAIL single_ack_after_busy: tx_busy=%b required 0", txb_a);
    end
    got = 16'hxxxx;
    if (log_a.size() == 2) got = {log_a[0], log_a[1]};
    checks++;
    if (got !== 16'hA25C) begin
      fails++;
      $display("FAIL single_bytes: got %h (n=%0d) required a25c", got, log_a.size());
    end
    repeat (6) @(negedge clk);
    checks++;
    if (ack_cnt_a - base !== 1) begin
      fails++;
      $display("FAIL single_ack_count: got %0d required 1", ack_cnt_a - base);
    end
  endtask

  task automatic test_contention();
    logic [23:0] seq;
    logic [7:0]  exp_bytes [12];
    int          n;
    int          err;
    int          repeats;
    exp_bytes = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA3, 8'h44,
                  8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA3, 8'h44};
    pulse_reset();
    log_a.delete();
    seq = '0;
    n = 0;
    din_a = {8'h44, 8'h33, 8'h22, 8'h11};
    req_a = 4'b1011;
    for (int i = 0; i < 1500 && n < 6; i++) begin
      @(negedge clk);
      if (ack_a != 4'b0) begin
        seq = {seq[19:0], ack_a};
        n++;
      end
    end
    req_a = 4'b0000;
    checks++;
    if (n != 6) begin
      fails++;
      $display("FAIL contention_ack_count: got %0d required 6", n);
    end
    checks++;
    if (seq !== 24'h128128) begin
      fails++;
      $display("FAIL contention_order: got %h required 128128", seq);
    end
    repeats = 0;
    for (int i = 0; i < 5; i++) if (seq[i*4 +: 4] == seq[(i+1)*4 +: 4]) repeats++;
    checks++;
    if (repeats != 0) begin
      fails++;
      $display("FAIL contention_twice_in_row: got %0d required 0", repeats);
    end
    err = (log_a.size() == 12) ? 0 : 1;
    if (err == 0) for (int i = 0; i < 12; i++) if (log_a[i] !== exp_bytes[i]) err++;
    checks++;
    if (err != 0) begin
      fails++;
      $display("FAIL contention_bytes: got %0d bad (n=%0d) required 0 bad", err, log_a.size());
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_no_header();
    bit ok;
    int base_rise;
    log_b.delete();
    base_rise = start_rises_b;
    din_b[15:8] = 8'hFF;
    req_b = 4'b0010;
    wait_ack_b(400, ok);
    req_b = 4'b0000;
    checks++;
    if (ok !== 1'b1 || ack_b !== 4'b0010) begin
      fails++;
      $display("FAIL nohdr_ack: got %b required 0010", ack_b);
    end
    checks++;
    if (log_b.size() != 1 || log_b[0] !== 8'hFF) begin
      fails++;
      $display("FAIL nohdr_bytes: got n=%0d required n=1 byte ff", log_b.size());
    end
    checks++;
    if (last_len_b != 4) begin
      fails++;
      $display("FAIL nohdr_start_len: got %0d required 4", last_len_b);
    end
    checks++;
    if (start_rises_b - base_rise != 1) begin
      fails++;
      $display("FAIL nohdr_start_rises: got %0d required 1", start_rises_b - base_rise);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int base_terr;
    int base_ack;
    pulse_reset();
    en_a = 1'b0;
    base_terr = terr_cnt_a;
    base_ack  = ack_cnt_a;
    din_a = {8'h00, 8'h00, 8'h5A, 8'h3C};
    req_a = 4'b0011;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (terr_cnt_a != base_terr) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL timeout_seen: got %b required 1", ok);
    end
    checks++;
    if (terr_cyc_a - start_rise_cyc_a != 64) begin
      fails++;
      $display("FAIL timeout_latency: got %0d required 64", terr_cyc_a - start_rise_cyc_a);
    end
    checks++;
    if (terr_a !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse_width: got %b required 0", terr_a);
    end
    checks++;
    if (ack_cnt_a != base_ack) begin
      fails++;
      $display("FAIL timeout_no_ack: got %0d required %0d", ack_cnt_a, base_ack);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start_a) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok !== 1'b1 || dtx_a !== 8'hA0) begin
      fails++;
      $display("FAIL timeout_regrant: got start=%b byte=%h required 1 a0", ok, dtx_a);
    end
    en_a = 1'b1;
    wait_ack_a(400, ok);
    checks++;
    if (ok !== 1'b1 || ack_a !== 4'b0001) begin
      fails++;
      $display("FAIL timeout_retry_ack: got %b required 0001", ack_a);
    end
    req_a[0] = 1'b0;
    wait_ack_a(400, ok);
    req_a = 4'b0000;
    checks++;
    if (ok !== 1'b1 || ack_a !== 4'b0010) begin
      fails++;
      $display("FAIL timeout_next_ack: got %b required 0010", ack_a);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int fall_at;
    int start_at;
    log_a.delete();
    din_a[31:24] = 8'h77;
    req_a = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (log_a.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || busy_a !== 1'b1 || txb_a !== 1'b1) begin
      fails++;
      $display("FAIL midframe_setup: got ok=%b busy=%b txb=%b required 1 1 1", ok, busy_a, txb_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack_a, start_a, busy_a, terr_a, dtx_a} !== 15'h0) begin
      fails++;
      $display("FAIL midframe_async_reset: got %h required 0", {ack_a, start_a, busy_a, terr_a, dtx_a});
    end
    @(negedge clk);
    reset = 1'b0;
    fall_at  = -1;
    start_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!txb_a && fall_at < 0) fall_at = i;
      if (start_a && start_at < 0) start_at = i;
      if (start_at >= 0) break;
    end
    checks++;
    if (fall_at < 0 || start_at <= fall_at) begin
      fails++;
      $display("FAIL midframe_no_overlap: got start@%0d fall@%0d required start after fall", start_at, fall_at);
    end
    wait_ack_a(400, ok);
    req_a = 4'b0000;
    checks++;
    if (ok !== 1'b1 || ack_a !== 4'b1000) begin
      fails++;
      $display("FAIL midframe_recover_ack: got %b required 1000", ack_a);
    end
    checks++;
    if (log_a.size() != 4 || log_a[2] !== 8'hA3 || log_a[3] !== 8'h77) begin
      fails++;
      $display("FAIL midframe_recover_bytes: got n=%0d required 4 ending a3 77", log_a.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_data_stability();
    checks++;
    if (viol_a != 0 || viol_b != 0) begin
      fails++;
      $display("FAIL data_stable_under_start: got %0d/%0d changes required 0/0", viol_a, viol_b);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    din_a = '0;
    din_b = '0;
    test_reset();
    test_single_header();
    test_contention();
    test_no_header();
    test_timeout();
    test_reset_midframe();
    test_data_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
